// File: rtl/vee_ctrl.sv
// vee_ctrl: EEPROM VEE supply sequencer (build with VEE_RETRY_EN for one automatic ramp retry).
module vee_ctrl #(
  parameter int RAMP_MAX   = 64,
  parameter int SETTLE_CYC = 4,
  parameter int DISCHG_CYC = 8,
  parameter int CNT_W      = 8
) (
  input  logic DOUB_BLF,
  input  logic rst,
  input  logic vee_req,
  input  logic tag_status,
  input  logic vee_det,
  output logic cp_en,
  output logic dis_en,
  output logic vee_rdy,
  output logic vee_timeout,
  output logic vee_drop
);
  typedef enum logic [2:0] {IDLE, RAMP, SETTLE, READY, DISCHG} state_t;
  localparam logic [CNT_W-1:0] RAMP_LAST = CNT_W'(RAMP_MAX - 1);
  localparam logic [CNT_W-1:0] STAB_DONE = CNT_W'(SETTLE_CYC);
  localparam logic [CNT_W-1:0] DIS_LAST  = CNT_W'(DISCHG_CYC - 1);
  state_t state, nxt;
  logic [CNT_W-1:0] ramp_cnt, stab_cnt, dis_cnt;
  logic det_m, det_s;
  logic in_ramp, shut, ready_hit, tmo, tmo_set, retry_back, ramp_entry;
  function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction
  assign in_ramp    = (state == RAMP) || (state == SETTLE);
  assign shut       = !vee_req || tag_status;
  assign ready_hit  = (state == SETTLE) && det_s && (stab_cnt == STAB_DONE);
  assign tmo        = in_ramp && !shut && !ready_hit && (ramp_cnt == RAMP_LAST);
  assign ramp_entry = (nxt == RAMP) && !in_ramp;
`ifdef VEE_RETRY_EN
  logic retry;
  // first timeout arms a retry; any other exit from the ramp path disarms it
  always_ff @(posedge DOUB_BLF) begin
    if (rst) retry <= 1'b0;
    else if (tmo) retry <= !retry;
    else if ((nxt == DISCHG && state != DISCHG) || nxt == IDLE || nxt == READY) retry <= 1'b0;
  end
  assign retry_back = retry && vee_req && !tag_status;
  assign tmo_set    = tmo && retry;
`else
  assign retry_back = 1'b0;
  assign tmo_set    = tmo;
`endif
  // two-flop synchroniser for the asynchronous comparator
  always_ff @(posedge DOUB_BLF) begin
    if (rst) {det_m, det_s} <= 2'b00;
    else {det_m, det_s} <= {vee_det, det_m};
  end
  // next-state decode; shutdown beats timeout, READY beats timeout
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = (vee_req && !tag_status) ? RAMP : IDLE;
      RAMP:    nxt = (shut || tmo) ? DISCHG : det_s ? SETTLE : RAMP;
      SETTLE:  nxt = (shut || tmo) ? DISCHG : ready_hit ? READY : det_s ? SETTLE : RAMP;
      READY:   nxt = shut ? DISCHG : det_s ? READY : RAMP;
      DISCHG:  nxt = (dis_cnt == DIS_LAST) ? (retry_back ? RAMP : IDLE) : DISCHG;
      default: nxt = IDLE;
    endcase
  end
  // state, counters and outputs registered from the next state
  always_ff @(posedge DOUB_BLF) begin
    if (rst) begin
      state       <= IDLE;
      ramp_cnt    <= '0;
      stab_cnt    <= '0;
      dis_cnt     <= '0;
      cp_en       <= 1'b0;
      dis_en      <= 1'b0;
      vee_rdy     <= 1'b0;
      vee_timeout <= 1'b0;
      vee_drop    <= 1'b0;
    end else begin
      state       <= nxt;
      ramp_cnt    <= ramp_entry ? '0 : in_ramp ? inc(ramp_cnt) : ramp_cnt;
      stab_cnt    <= (nxt == SETTLE) ? ((state == SETTLE) ? inc(stab_cnt) : CNT_W'(1)) : '0;
      dis_cnt     <= (state == DISCHG) ? inc(dis_cnt) : '0;
      cp_en       <= (nxt == RAMP) || (nxt == SETTLE) || (nxt == READY);
      dis_en      <= nxt == DISCHG;
      vee_rdy     <= nxt == READY;
      vee_drop    <= (state == READY) && (nxt == RAMP);
      vee_timeout <= ramp_entry ? 1'b0 : tmo_set ? 1'b1 : vee_timeout;
    end
  end
endmodule
